send_pkt_preamble_arb: RTL and testbench

//  Multi-channel USB host packet-PID issuer with per-channel low-speed PRE insertion.

---
 rtl/send_pkt_preamble_arb_if.sv | 28 ++
 rtl/send_pkt_preamble_arb.sv | 144 ++++++++++++++
 tb/tb_send_pkt_preamble_arb.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/send_pkt_preamble_arb_if.sv
// Request/transmit bundle between host transaction engines, the PID arbiter and the packet sender.
// The slave modport is the arbiter's view; master is the environment driving requests and tx_rdy.
interface send_pkt_preamble_arb_if #(
    parameter int NCH   = 2,
    parameter int PID_W = 4
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       req_wen;
    logic [NCH*PID_W-1:0] req_pid;
    logic [NCH-1:0]       req_preamble;
    logic [NCH-1:0]       req_ready;
    logic [PID_W-1:0]     tx_pid;
    logic                 tx_wen;
    logic                 tx_rdy;
    logic                 busy;
    logic [GW-1:0]        grant_ch;

    modport master (
        output req_wen, req_pid, req_preamble, tx_rdy,
        input  req_ready, tx_pid, tx_wen, busy, grant_ch
    );

    modport slave (
        input  req_wen, req_pid, req_preamble, tx_rdy,
        output req_ready, tx_pid, tx_wen, busy, grant_ch
    );
endinterface

// File: rtl/send_pkt_preamble_arb.sv
// Round-robin USB PID issuer: serves one channel at a time, optionally prefixing a PRE PID
// and a hub set-up gap for low-speed channels before handing the packet PID to the sender.
module send_pkt_preamble_arb #(
    parameter int                      NCH         = 2,
    parameter int                      PID_W       = 4,
    parameter logic [PID_W-1:0]        PRE_PID     = 4'hC,
    parameter logic [(1<<PID_W)-1:0]   EXEMPT_MASK = 16'h0020,
    parameter int                      GAP_CYCLES  = 4,
    parameter int                      GAP_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    send_pkt_preamble_arb_if.slave    bus
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_CHECK,
        S_PRE_WAIT, S_PRE_ISSUE, S_PRE_DROP, S_PRE_DONE, S_GAP,
        S_PKT_WAIT, S_PKT_ISSUE, S_PKT_DROP, S_PKT_DONE, S_COMPLETE
    } state_e;

    state_e           state_q;
    logic [NCH-1:0]   req_ready_q;
    logic [NCH-1:0]   pre_q;
    logic [PID_W-1:0] pid_q [NCH];
    logic [GW-1:0]    rr_q;
    logic [GW-1:0]    grant_q;
    logic [PID_W-1:0] tx_pid_q;
    logic             tx_wen_q;
    logic             busy_q;
    logic [GAP_W-1:0] gap_q;

    logic [NCH-1:0]   accept;
    logic             arb_valid;
    logic [GW-1:0]    arb_ch;
    logic [GW-1:0]    cand;
    logic             need_pre;

    // A channel is pending exactly while its req_ready is low.
    assign accept   = bus.req_wen & req_ready_q;
    assign need_pre = pre_q[grant_q] && !EXEMPT_MASK[pid_q[grant_q]];

    // NOTE: payload slots carry no reset; they are only read after a capture has filled them.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (accept[ch]) begin
                pid_q[ch] <= bus.req_pid[ch*PID_W +: PID_W];
                pre_q[ch] <= bus.req_preamble[ch];
            end
        end
    end

    // Scan downwards so the channel closest after the RR pointer is the last (winning) hit.
    always_comb begin
        arb_valid = 1'b0;
        arb_ch    = '0;
        cand      = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = GW'((int'(rr_q) + i) % NCH);
            if (!req_ready_q[cand]) begin
                arb_valid = 1'b1;
                arb_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            req_ready_q <= '1;
            rr_q        <= GW'(NCH - 1);
            grant_q     <= '0;
            tx_pid_q    <= '0;
            tx_wen_q    <= 1'b0;
            busy_q      <= 1'b0;
            gap_q       <= '0;
        end else begin
            req_ready_q <= req_ready_q & ~accept;
            tx_wen_q    <= 1'b0;
            case (state_q)
                S_INIT: state_q <= S_IDLE;
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_ch;
                        rr_q    <= arb_ch;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: state_q <= need_pre ? S_PRE_WAIT : S_PKT_WAIT;
                S_PRE_WAIT: begin
                    if (bus.tx_rdy) begin
                        tx_wen_q <= 1'b1;
                        tx_pid_q <= PRE_PID;
                        state_q  <= S_PRE_ISSUE;
                    end
                end
                S_PRE_ISSUE: state_q <= S_PRE_DROP;
                S_PRE_DROP:  state_q <= S_PRE_DONE;
                S_PRE_DONE: begin
                    if (bus.tx_rdy) begin
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_PKT_WAIT;
                        end else begin
                            gap_q   <= GAP_W'(GAP_CYCLES);
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_q <= gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) state_q <= S_PKT_WAIT;
                end
                S_PKT_WAIT: begin
                    if (bus.tx_rdy) begin
                        tx_wen_q <= 1'b1;
                        tx_pid_q <= pid_q[grant_q];
                        state_q  <= S_PKT_ISSUE;
                    end
                end
                S_PKT_ISSUE: state_q <= S_PKT_DROP;
                S_PKT_DROP:  state_q <= S_PKT_DONE;
                S_PKT_DONE: begin
                    if (bus.tx_rdy) begin
                        req_ready_q[grant_q] <= 1'b1;
                        state_q              <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_pid    = tx_pid_q;
    assign bus.tx_wen    = tx_wen_q;
    assign bus.busy      = busy_q;
    assign bus.grant_ch  = grant_q;
endmodule

// File: tb/tb_send_pkt_preamble_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic compared every cycle against
// a transaction-timeline reference model of the arbiter.
module tb_send_pkt_preamble_arb;
    localparam int               NCH        = 2;
    localparam int               PID_W      = 4;
    localparam logic [3:0]       PRE_PID    = 4'hC;
    localparam logic [15:0]      EXEMPT     = 16'h0020;
    localparam int               GAP_CYCLES = 4;

    bit clk;
    bit rst;
    bit chk_en;
    int n_checks;
    int n_fail;
    int n_pulses;

    send_pkt_preamble_arb_if #(.NCH(NCH), .PID_W(PID_W)) bus ();

    send_pkt_preamble_arb #(
        .NCH(NCH), .PID_W(PID_W), .PRE_PID(PRE_PID), .EXEMPT_MASK(EXEMPT),
        .GAP_CYCLES(GAP_CYCLES), .GAP_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [NCH-1:0]   m_ready = '1;
    bit [PID_W-1:0] m_pid [NCH];
    bit             m_pre [NCH];
    int             m_rr = NCH - 1;
    bit             m_wen;
    bit [PID_W-1:0] m_tx;
    bit             m_busy;
    int             m_grant;
    bit             m_abort;
    bit             s_rdy;
    bit [NCH-1:0]   pend_snap;

    // One clock edge: request capture and reset; pend_snap keeps the pre-edge pending set.
    task automatic tick();
        @(posedge clk);
        s_rdy = bus.tx_rdy;
        m_wen = 1'b0;
        if (rst) begin
            m_abort   = 1'b1;
            m_ready   = '1;
            m_rr      = NCH - 1;
            m_tx      = '0;
            m_busy    = 1'b0;
            m_grant   = 0;
            pend_snap = '0;
            return;
        end
        pend_snap = ~m_ready;
        for (int c = 0; c < NCH; c++) begin
            if (bus.req_wen[c] && m_ready[c]) begin
                m_pid[c]   = bus.req_pid[c*PID_W +: PID_W];
                m_pre[c]   = bus.req_preamble[c];
                m_ready[c] = 1'b0;
            end
        end
    endtask

    task automatic wait_rdy();
        do begin
            tick();
            if (m_abort) return;
        end while (!s_rdy);
    endtask

    // One complete transaction timeline, from idle wait to return to idle.
    task automatic serve();
        int g;
        bit need_pre;
        do begin
            tick();
            if (m_abort) return;
        end while (pend_snap == '0);
        g = -1;
        for (int k = 1; k <= NCH; k++)
            if (g < 0 && pend_snap[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
        m_rr = g; m_grant = g; m_busy = 1'b1;
        tick(); if (m_abort) return;
        need_pre = m_pre[g] && !EXEMPT[m_pid[g]];
        if (need_pre) begin
            wait_rdy(); if (m_abort) return;
            m_wen = 1'b1; m_tx = PRE_PID;
            tick(); if (m_abort) return;
            tick(); if (m_abort) return;
            wait_rdy(); if (m_abort) return;
            for (int k = 0; k < GAP_CYCLES; k++) begin
                tick(); if (m_abort) return;
            end
        end
        wait_rdy(); if (m_abort) return;
        m_wen = 1'b1; m_tx = m_pid[g];
        tick(); if (m_abort) return;
        tick(); if (m_abort) return;
        wait_rdy(); if (m_abort) return;
        m_ready[g] = 1'b1;
        tick(); if (m_abort) return;
        m_busy = 1'b0;
    endtask

    initial begin
        forever begin
            m_abort = 1'b0;
            tick();
            if (m_abort) continue;
            while (!m_abort) serve();
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_wen",    32'(bus.tx_wen),    32'(m_wen));
            check("tx_pid",    32'(bus.tx_pid),    32'(m_tx));
            check("busy",      32'(bus.busy),      32'(m_busy));
            check("grant_ch",  32'(bus.grant_ch),  32'(m_grant));
            check("req_ready", 32'(bus.req_ready), 32'(m_ready));
            if (bus.tx_wen === 1'b1) n_pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic request(input int ch, input logic [3:0] pid, input bit pre);
        bus.req_wen[ch]                    = 1'b1;
        bus.req_pid[ch*PID_W +: PID_W]     = pid;
        bus.req_preamble[ch]               = pre;
        @(negedge clk);
        bus.req_wen = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_wen      = '0;
        bus.req_pid      = '0;
        bus.req_preamble = '0;
        bus.tx_rdy       = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // plain packet, no preamble
        n_pulses = 0;
        request(0, 4'h1, 1'b0);
        cyc(10);
        check("t1_pulses", 32'(n_pulses), 32'd1);

        // low-speed packet: PRE, gap, packet
        n_pulses = 0;
        request(0, 4'h9, 1'b1);
        cyc(20);
        check("t2_pulses", 32'(n_pulses), 32'd2);

        // SOF is exempt from preamble
        n_pulses = 0;
        request(1, 4'h5, 1'b1);
        cyc(12);
        check("t3_pulses", 32'(n_pulses), 32'd1);

        // simultaneous requests right after reset, then sustained requests on both
        do_reset();
        bus.req_wen = 2'b11;
        bus.req_pid = 8'h32;
        bus.req_preamble = 2'b00;
        @(negedge clk);
        bus.req_wen = '0;
        cyc(20);
        for (int i = 0; i < 60; i++) begin
            bus.req_wen = bus.req_ready;
            bus.req_pid = 8'(i * 7);
            bus.req_preamble = 2'(i);
            @(negedge clk);
        end
        bus.req_wen = '0;
        cyc(30);

        // sender stalled in PKT_WAIT
        n_pulses = 0;
        bus.tx_rdy = 1'b0;
        request(0, 4'h6, 1'b0);
        cyc(10);
        check("t5_stall_pulses", 32'(n_pulses), 32'd0);
        check("t5_stall_busy", 32'(bus.busy), 32'd1);
        bus.tx_rdy = 1'b1;
        cyc(10);
        check("t5_release_pulses", 32'(n_pulses), 32'd1);

        // reset in the middle of the hub gap
        request(0, 4'h9, 1'b1);
        cyc(6);
        n_pulses = 0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(10);
        check("t6_no_pid_after_rst", 32'(n_pulses), 32'd0);

        // randomized traffic with flaky tx_rdy and occasional resets
        for (int i = 0; i < 4000; i++) begin
            bus.tx_rdy       = ($urandom_range(0, 3) != 0);
            bus.req_wen      = NCH'($urandom);
            bus.req_pid      = ($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom);
            bus.req_preamble = NCH'($urandom);
            rst              = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst         = 1'b0;
        bus.req_wen = '0;
        bus.tx_rdy  = 1'b1;
        cyc(40);
        check("drain_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
